mem_port_arbiter: RTL and testbench

- Shares the core's single 32-bit RAM port between instruction fetch (IF requester) and load/store (MEM requester).
- Sits between the pipeline's fetch/memory stages and the external ram_* interface.
- Registers the RAM request, waits for ram_ack, and returns read data with a one-cycle ready pulse.
- Produces stall requests that freeze the pipeline while a requester waits.

---
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one 32-bit RAM port between fetch (IF) and load/store (MEM).
//            Optional ack timeout with sticky err: define MEM_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ready_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_data_i,
    input  logic        ram_ack_i,
    output logic        stall_if_o,
    output logic        stall_mem_o,
    output logic        err_o
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_IF_BUSY  = 2'd1;
    localparam logic [1:0] S_MEM_BUSY = 2'd2;

    localparam int            SW           = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_LIMIT);

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          discard_q, discard_d;

    logic          ram_ce_q, ram_we_q;
    logic [3:0]    ram_sel_q;
    logic [31:0]   ram_addr_q, ram_wdata_q;
    logic [31:0]   if_rdata_q, mem_rdata_q;
    logic          if_ready_q, mem_ready_q;

    logic          w_starved, w_grant_if, w_grant_mem, w_done, w_timeout;
    logic [31:0]   w_rdata;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q;

    assign w_timeout = (state_q != S_IDLE) && !ram_ack_i && (tmo_q == TW'(TIMEOUT - 1));
    assign tmo_d     = ((state_q == S_IDLE) || w_done) ? '0 : tmo_q + TW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_q | w_timeout;
        end
    end

    assign err_o = err_q;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_grant_mem) begin
                    state_d = S_MEM_BUSY;
                end else if (w_grant_if) begin
                    state_d = S_IF_BUSY;
                end
            end
            S_IF_BUSY, S_MEM_BUSY: begin
                if (w_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // MEM wins ties (older instruction) unless IF has been passed over STARVE_LIMIT times.
    always_comb begin
        w_starved   = if_req_i && (starve_q == C_STARVE_MAX);
        w_grant_if  = (state_q == S_IDLE) && if_req_i && (!mem_req_i || w_starved);
        w_grant_mem = (state_q == S_IDLE) && mem_req_i && !w_grant_if;
        w_done      = (state_q != S_IDLE) && (ram_ack_i || w_timeout);
        w_rdata     = w_timeout ? 32'h0 : ram_data_i;

        starve_d = starve_q;
        if (state_q == S_IDLE) begin
            if (w_grant_if || !if_req_i) begin
                starve_d = '0;
            end else if (w_grant_mem && !w_starved) begin
                starve_d = starve_q + SW'(1);
            end
        end

        discard_d = discard_q;
        if (w_done) begin
            discard_d = 1'b0;
        end else if (if_flush_i && (w_grant_if || (state_q == S_IF_BUSY))) begin
            discard_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q    <= '0;
            discard_q   <= 1'b0;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_sel_q   <= 4'h0;
            ram_addr_q  <= 32'h0;
            ram_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            discard_q   <= discard_d;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;

            if (w_grant_if) begin
                ram_ce_q    <= 1'b1;
                ram_we_q    <= 1'b0;
                ram_sel_q   <= 4'hF;
                ram_addr_q  <= if_addr_i;
                ram_wdata_q <= 32'h0;
            end else if (w_grant_mem) begin
                ram_ce_q    <= 1'b1;
                ram_we_q    <= mem_we_i;
                ram_sel_q   <= mem_sel_i;
                ram_addr_q  <= mem_addr_i;
                ram_wdata_q <= mem_wdata_i;
            end else if (w_done) begin
                ram_ce_q <= 1'b0;
            end

            // A flush arriving on the completion edge still suppresses the result.
            if (w_done) begin
                if (state_q == S_IF_BUSY) begin
                    if_rdata_q <= w_rdata;
                    if_ready_q <= !(discard_q || if_flush_i);
                end else begin
                    mem_rdata_q <= w_rdata;
                    mem_ready_q <= 1'b1;
                end
            end
        end
    end

    assign ram_ce_o    = ram_ce_q;
    assign ram_we_o    = ram_we_q;
    assign ram_sel_o   = ram_sel_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign if_ready_o  = if_ready_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_ready_o = mem_ready_q;
    assign stall_if_o  = if_req_i & ~if_ready_q;
    assign stall_mem_o = mem_req_i & ~mem_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed + random bench for mem_port_arbiter against a cycle model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int SL = 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
    localparam int TMO    = 8;
`else
    localparam bit TMO_EN = 1'b0;
    localparam int TMO    = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, mem_req, mem_we, ram_ack;
    logic [31:0] if_addr, mem_addr, mem_wdata, ram_data;
    logic [3:0]  mem_sel;
    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
    logic        if_ready, mem_ready, ram_ce, ram_we, stall_if, stall_mem, err;
    logic [3:0]  ram_sel;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .STARVE_LIMIT(SL)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .TIMEOUT(TMO)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
        .if_rdata_o(if_rdata), .if_ready_o(if_ready),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel),
        .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_rdata_o(mem_rdata), .mem_ready_o(mem_ready),
        .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_sel_o(ram_sel),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
        .ram_data_i(ram_data), .ram_ack_i(ram_ack),
        .stall_if_o(stall_if), .stall_mem_o(stall_mem), .err_o(err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: owner 0 = none, 1 = fetch, 2 = load/store.
    int          m_own, m_starve, m_busy_n;
    logic        m_ce, m_we, m_ifrdy, m_memrdy, m_disc, m_err;
    logic [3:0]  m_sel;
    logic [31:0] m_addr, m_wdata, m_ifrd, m_memrd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_own = 0; m_starve = 0; m_busy_n = 0;
        m_ce = 0; m_we = 0; m_ifrdy = 0; m_memrdy = 0; m_disc = 0; m_err = 0;
        m_sel = 4'h0; m_addr = 32'h0; m_wdata = 32'h0; m_ifrd = 32'h0; m_memrd = 32'h0;
    endtask

    task automatic model_edge();
        bit          iw, mw, fin;
        logic [31:0] d;
        m_ifrdy  = 1'b0;
        m_memrdy = 1'b0;
        if (m_own == 0) begin
            iw = if_req && (!mem_req || m_starve == SL);
            mw = mem_req && !iw;
            m_busy_n = 0;
            if (iw) begin
                m_own = 1; m_ce = 1; m_we = 0; m_sel = 4'hF; m_addr = if_addr;
                m_starve = 0; m_disc = if_flush;
            end else begin
                if (mw) begin
                    m_own = 2; m_ce = 1; m_we = mem_we; m_sel = mem_sel;
                    m_addr = mem_addr; m_wdata = mem_wdata;
                end
                if (!if_req) m_starve = 0;
                else if (mw && m_starve < SL) m_starve++;
            end
        end else begin
            m_busy_n++;
            fin = ram_ack || (TMO_EN && m_busy_n == TMO);
            if (fin) begin
                d = ram_ack ? ram_data : 32'h0;
                if (!ram_ack) m_err = 1'b1;
                if (m_own == 1) begin
                    m_ifrd = d; m_ifrdy = !(m_disc || if_flush);
                end else begin
                    m_memrd = d; m_memrdy = 1'b1;
                end
                m_ce = 0; m_own = 0; m_disc = 0;
            end else if (m_own == 1 && if_flush) begin
                m_disc = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("ram_ce", ram_ce, m_ce);
        if (m_ce) begin
            chk("ram_we", ram_we, m_we);
            chk("ram_sel", ram_sel, m_sel);
            chk("ram_addr", ram_addr, m_addr);
            if (m_we) chk("ram_wdata", ram_wdata, m_wdata);
        end
        chk("if_ready", if_ready, m_ifrdy);
        chk("mem_ready", mem_ready, m_memrdy);
        chk("if_rdata", if_rdata, m_ifrd);
        chk("mem_rdata", mem_rdata, m_memrd);
        chk("stall_if", stall_if, if_req & ~m_ifrdy);
        chk("stall_mem", stall_mem, mem_req & ~m_memrdy);
        chk("err", err, m_err);
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   grants[$];
        bit   exp_we[6];
        logic prev_ce;
        int   n;

        rst = 1'b1;
        if_req = 0; if_flush = 0; if_addr = 0;
        mem_req = 0; mem_we = 0; mem_sel = 0; mem_addr = 0; mem_wdata = 0;
        ram_ack = 0; ram_data = 0;
        m_reset();
        @(negedge clk); @(negedge clk);
        check_all();
        rst = 1'b0;
        tick();

        // Single fetch, ack in the first ram_ce cycle.
        if_req = 1; if_addr = 32'h100;
        tick();
        chk("t1_ce", ram_ce, 1);
        chk("t1_stall", stall_if, 1);
        ram_ack = 1; ram_data = 32'h3C010101;
        tick();
        chk("t1_ready", if_ready, 1);
        chk("t1_rdata", if_rdata, 32'h3C010101);
        chk("t1_ce_off", ram_ce, 0);
        if_req = 0; ram_ack = 0;
        tick();

        // Simultaneous requests: store first, fetch after.
        if_req = 1; if_addr = 32'h104;
        mem_req = 1; mem_we = 1; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF; mem_sel = 4'b0011;
        tick();
        chk("t2_we", ram_we, 1);
        chk("t2_sel", ram_sel, 4'b0011);
        chk("t2_wdata", ram_wdata, 32'hDEADBEEF);
        ram_ack = 1; ram_data = $urandom;
        tick();
        chk("t2_mready", mem_ready, 1);
        mem_req = 0; ram_ack = 0;
        tick();
        chk("t2_if_grant_we", ram_we, 0);
        chk("t2_if_grant_sel", ram_sel, 4'hF);
        chk("t2_if_grant_addr", ram_addr, 32'h104);
        ram_ack = 1; ram_data = $urandom;
        tick();
        chk("t2_iready", if_ready, 1);
        if_req = 0; ram_ack = 0;
        tick();

        // Starvation: MEM held continuously, IF pending.
        exp_we = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        mem_req = 1; mem_we = 1; mem_addr = 32'h240; mem_sel = 4'hF; mem_wdata = 32'h5A5A5A5A;
        if_req = 1; if_addr = 32'h108; ram_ack = 1;
        prev_ce = ram_ce;
        for (int c = 0; c < 40 && grants.size() < 6; c++) begin
            tick();
            if (ram_ce && !prev_ce) grants.push_back(ram_we);
            prev_ce = ram_ce;
            if (if_ready) if_req = 0;
        end
        chk("t3_grant_count", grants.size(), 6);
        for (int i = 0; i < grants.size() && i < 6; i++) chk($sformatf("t3_grant%0d", i), grants[i], exp_we[i]);
        mem_req = 0;
        tick(); tick();
        ram_ack = 0;
        tick();

        // Flush during IF_BUSY with a 3-cycle ack delay.
        if_req = 1; if_addr = 32'h300;
        tick();
        if_flush = 1;
        tick();
        if_flush = 0; if_addr = 32'h304;
        tick();
        ram_ack = 1; ram_data = 32'hCAFEF00D;
        tick();
        chk("t4_suppressed", if_ready, 0);
        chk("t4_ce_off", ram_ce, 0);
        ram_ack = 0;
        tick();
        chk("t4_refetch_addr", ram_addr, 32'h304);
        ram_ack = 1; ram_data = 32'h12345678;
        tick();
        chk("t4_ready", if_ready, 1);
        chk("t4_rdata", if_rdata, 32'h12345678);
        if_req = 0; ram_ack = 0;
        tick();

        // Asynchronous reset in the middle of MEM_BUSY.
        mem_req = 1; mem_we = 0; mem_addr = 32'h400; mem_sel = 4'hF;
        tick();
        tick();
        #2;
        rst = 1'b1; mem_req = 0;
        #1;
        chk("t5_ce", ram_ce, 0);
        chk("t5_mready", mem_ready, 0);
        chk("t5_stall_mem", stall_mem, 0);
        chk("t5_stall_if", stall_if, 0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all();
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // No ack ever: abort after TMO busy cycles.
        mem_req = 1; mem_we = 0; mem_addr = 32'h500; ram_ack = 0;
        n = 0;
        for (int c = 0; c < 30 && !mem_ready; c++) begin
            tick();
            n++;
        end
        chk("t6_latency", n, TMO + 1);
        chk("t6_rdata", mem_rdata, 32'h0);
        chk("t6_err", err, 1);
        mem_req = 0;
        tick(); tick();
        chk("t6_err_sticky", err, 1);
`endif

        // Randomised traffic.
        for (int c = 0; c < 1500; c++) begin
            if_flush = ($urandom_range(0, 15) == 0);
            if (if_req) begin
                if (if_ready) begin
                    if_req = 1'($urandom_range(0, 1));
                    if_addr = $urandom;
                end else if (if_flush) begin
                    if_addr = $urandom;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom;
            end
            if ((mem_req && mem_ready) || (!mem_req && $urandom_range(0, 2) == 0)) begin
                mem_req   = mem_req ? 1'($urandom_range(0, 1)) : 1'b1;
                mem_we    = 1'($urandom_range(0, 1));
                mem_sel   = 4'($urandom);
                mem_addr  = $urandom;
                mem_wdata = $urandom;
            end
            ram_ack  = ($urandom_range(0, 2) == 0);
            ram_data = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
